// File: rtl/bit_serializer_if.sv
// Parallel word handshake into the bit serializer: the producer drives din/din_valid,
// the serializer answers with din_ready.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: streams WIDTH-bit words one bit per clk with no inter-word gap.
// Optional trailing even-parity bit per word when SER_PARITY_EN is defined.
module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  bit_serializer_if.slave     bus,
  output logic                signal,
  output logic                signal_valid,
  output logic                frame_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             last_bit;
  logic             xfer;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  // Bit that leaves first from a word, and the word after that bit has been consumed.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign last_bit = (state == SHIFT) && (cnt == LAST_IDX);

`ifdef SER_PARITY_EN
  assign bus.din_ready = (state == IDLE) || (state == PARITY);
`else
  assign bus.din_ready = (state == IDLE) || last_bit;
`endif

  assign xfer = bus.din_valid && bus.din_ready;

  // A transfer always wins: it restarts the frame from IDLE, the last bit, or the parity slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      signal       <= IDLE_LEVEL;
      signal_valid <= 1'b0;
      frame_done   <= 1'b0;
`ifdef SER_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (xfer) begin
        state        <= SHIFT;
        cnt          <= '0;
        shreg        <= advance(bus.din);
        signal       <= head_bit(bus.din);
        signal_valid <= 1'b1;
`ifdef SER_PARITY_EN
        par          <= ^bus.din;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (last_bit) begin
              cnt <= '0;
`ifdef SER_PARITY_EN
              state        <= PARITY;
              signal       <= par;
              signal_valid <= 1'b1;
              frame_done   <= 1'b1;
`else
              state        <= IDLE;
              signal       <= IDLE_LEVEL;
              signal_valid <= 1'b0;
`endif
            end else begin
              cnt          <= cnt + CW'(1);
              shreg        <= advance(shreg);
              signal       <= head_bit(shreg);
              signal_valid <= 1'b1;
`ifndef SER_PARITY_EN
              frame_done   <= (cnt == PRE_LAST);
`endif
            end
          end
`ifdef SER_PARITY_EN
          PARITY: begin
            state        <= IDLE;
            signal       <= IDLE_LEVEL;
            signal_valid <= 1'b0;
          end
`endif
          default: begin
            state        <= IDLE;
            signal       <= IDLE_LEVEL;
            signal_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an MSB-first and an LSB-first instance run in lockstep
// from the same word stream; expected bits are queued at each transfer and retired per cycle.
module tb_bit_serializer;
  localparam int unsigned WIDTH      = 8;
  localparam bit          IDLE_LEVEL = 1'b0;
`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  wire  [1:0]       sig, sv, fd, rdy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_done [2] = '{0, 0};
  int seen_done[2] = '{0, 0};
  exp_t q_m[$];
  exp_t q_l[$];

  bit_serializer_if #(.WIDTH(WIDTH)) bus_m ();
  bit_serializer_if #(.WIDTH(WIDTH)) bus_l ();

  assign bus_m.din       = din;
  assign bus_m.din_valid = din_valid;
  assign bus_l.din       = din;
  assign bus_l.din_valid = din_valid;
  assign rdy[0]          = bus_m.din_ready;
  assign rdy[1]          = bus_l.din_ready;

  bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_LEVEL)) dut_msb (
    .clk(clk), .rst(rst), .bus(bus_m),
    .signal(sig[0]), .signal_valid(sv[0]), .frame_done(fd[0])
  );

  bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_LEVEL)) dut_lsb (
    .clk(clk), .rst(rst), .bus(bus_l),
    .signal(sig[1]), .signal_valid(sv[1]), .frame_done(fd[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle of one instance: `have` says whether the scoreboard expects a bit this cycle.
  task automatic mon(input int d, input bit have, input exp_t e);
    string n;
    n = (d == 0) ? "msb" : "lsb";
    check({n, "_ready"},  32'(rdy[d]), 32'(!have || e.last));
    check({n, "_valid"},  32'(sv[d]),  32'(have));
    check({n, "_signal"}, 32'(sig[d]), have ? 32'(e.b) : 32'(IDLE_LEVEL));
    check({n, "_done"},   32'(fd[d]),  32'(have && e.last));
    if (have && e.last) exp_done[d]++;
    if (fd[d] === 1'b1) seen_done[d]++;
  endtask

  // Expected bits are queued on the accepting edge, in each instance's send order.
  always @(posedge clk) begin
    if (rst && din_valid && rdy[0]) begin
      for (int k = 0; k < int'(WIDTH); k++) begin
        q_m.push_back('{b: din[WIDTH-1-k], last: !PAR_EN && (k == int'(WIDTH) - 1)});
        q_l.push_back('{b: din[k],         last: !PAR_EN && (k == int'(WIDTH) - 1)});
      end
      if (PAR_EN) begin
        q_m.push_back('{b: ^din, last: 1'b1});
        q_l.push_back('{b: ^din, last: 1'b1});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      q_m.delete();
      q_l.delete();
      mon(0, 1'b0, '0);
      mon(1, 1'b0, '0);
    end else begin
      mon(0, q_m.size() != 0, (q_m.size() != 0) ? q_m[0] : '0);
      mon(1, q_l.size() != 0, (q_l.size() != 0) ? q_l[0] : '0);
      if (q_m.size() != 0) void'(q_m.pop_front());
      if (q_l.size() != 0) void'(q_l.pop_front());
    end
  end

  // Presents a word and holds it until an edge where the serializer is ready.
  task automatic send(input logic [WIDTH-1:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      ok = rdy[0];
      @(posedge clk);
    end
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = WIDTH'($urandom);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #20 rst = 1'b1;
    idle(4);

    send(8'hA5);
    idle(10);

    send(8'hA5);
    send(8'h3C);
    idle(10);

    send(8'h05);
    idle(3);

    // valid raised and dropped while busy must neither transfer nor disturb the word in flight
    send(8'h96);
    @(negedge clk);
    din = 8'h00;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = 8'hFF;
    idle(10);

    // async reset mid-word: outputs drop at once and the word is abandoned
    send(8'hFF);
    idle(3);
    #2 rst = 1'b0;
    #1;
    check("rst_valid_msb", 32'(sv[0]), 32'd0);
    check("rst_valid_lsb", 32'(sv[1]), 32'd0);
    check("rst_signal_msb", 32'(sig[0]), 32'(IDLE_LEVEL));
    check("rst_done_msb", 32'(fd[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    send(8'hA5);
    idle(10);

    repeat (8) begin
      send(WIDTH'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2 * WIDTH + 4);

    check("frames_msb", 32'(seen_done[0]), 32'(exp_done[0]));
    check("frames_lsb", 32'(seen_done[1]), 32'(exp_done[1]));
    check("q_empty_msb", 32'(q_m.size()), 32'd0);
    check("q_empty_lsb", 32'(q_l.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
